rx_lane_align: RTL and testbench

//  Multi-lane word aligner that sits after the per-lane 1:8 SIPO deserialisers, in the px_clk domain.
//  Per lane, it normalises raw W-bit words (bit order and polarity), then finds the bit offset at which
//  the training word appears. It locks that offset with a per-lane FSM and outputs aligned words.
//  It also flags loss of alignment, so the sensor parser downstream sees word-aligned pixel data on every lane.

---
 rtl/rx_align_pkg.sv | 14 +
 rtl/rx_lane_align_fsm.sv | 156 +++++++++++++++
 rtl/rx_lane_align.sv | 54 +++++
 tb/tb_rx_lane_align.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rx_align_pkg.sv
// Shared types and helpers for the rx lane aligner (rx_lane_align and its per-lane FSM).
package rx_align_pkg;

    localparam int W_DEF = 8;
    localparam int OFS_W = $clog2(W_DEF);

    typedef enum logic [1:0] {HUNT, CHECK, LOCKED} align_state_t;

    // Raw bit index that lands at normalised position j of a w-bit word when bit order is reversed.
    function automatic int bitrev(input int j, input int w);
        return w - 1 - j;
    endfunction

endpackage

// File: rtl/rx_lane_align_fsm.sv
// One lane of the aligner: normalise, window, offset search/lock FSM and aligned-word select.
// Optional macro RX_ALIGN_STATS_EN builds the saturating LOCKED->HUNT relock counter.
//
// state  | meaning
// HUNT   | searching every offset of the window for the training word
// CHECK  | offset chosen, counting consecutive training matches
// LOCKED | offset confirmed, counting consecutive training misses
module rx_lane_align_fsm
    import rx_align_pkg::*;
#(
    parameter int           W           = W_DEF,
    parameter int           OW          = $clog2(W),
    parameter bit           INVERT      = 1'b0,
    parameter bit           BIT_REVERSE = 1'b1,
    parameter logic [W-1:0] TRAIN_WORD  = 'hF0,
    parameter int           LOCK_CNT    = 4,
    parameter int           LOSS_CNT    = 8
) (
    input  logic          px_clk,
    input  logic          px_reset,
    input  logic [W-1:0]  raw,
    input  logic          train_mode,
    input  logic          align_req,
    output logic [W-1:0]  data,
    output logic          locked,
    output logic [OW-1:0] offset,
    output logic [15:0]   relock_cnt
);

    localparam logic [3:0] LOCK_N = 4'(LOCK_CNT);
    localparam logic [7:0] LOSS_N = 8'(LOSS_CNT);

    logic [W-1:0]   norm_n;
    logic [W-1:0]   norm_q;
    logic [2*W-1:0] win_q;
    logic [W-1:0]   cand [W];
    logic [W-1:0]   match;
    logic [OW-1:0]  first_k;
    logic           any_match;
    logic           cur_match;

    align_state_t   state, state_n;
    logic [3:0]     cnt, cnt_n, cnt_inc;
    logic [7:0]     err, err_n, err_inc;
    logic [OW-1:0]  ofs, ofs_n;

    for (genvar j = 0; j < W; j++) begin : g_norm
        localparam int SRC = BIT_REVERSE ? bitrev(j, W) : j;
        assign norm_n[j] = raw[SRC] ^ INVERT;
    end

    // Offset 0 is the older word in full; higher offsets slide toward the newer one.
    for (genvar k = 0; k < W; k++) begin : g_cand
        assign cand[k]  = win_q[2*W-1-k -: W];
        assign match[k] = (cand[k] == TRAIN_WORD);
    end

    always_comb begin
        first_k = '0;
        for (int k = W - 1; k >= 0; k--) begin
            if (match[k]) first_k = OW'(k);
        end
    end

    assign any_match = |match;
    assign cur_match = match[ofs];
    assign cnt_inc   = (cnt == 4'hF)  ? cnt : cnt + 4'd1;
    assign err_inc   = (err == 8'hFF) ? err : err + 8'd1;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        err_n   = err;
        ofs_n   = ofs;
        if (align_req) begin
            state_n = HUNT;
            cnt_n   = '0;
            err_n   = '0;
        end else begin
            case (state)
                HUNT: begin
                    if (train_mode && any_match) begin
                        ofs_n   = first_k;
                        cnt_n   = 4'd1;
                        state_n = CHECK;
                    end
                end
                CHECK: begin
                    if (train_mode) begin
                        if (cur_match) begin
                            cnt_n = cnt_inc;
                            if (cnt_inc >= LOCK_N) state_n = LOCKED;
                        end else begin
                            cnt_n   = '0;
                            state_n = HUNT;
                        end
                    end
                end
                LOCKED: begin
                    if (train_mode) begin
                        if (cur_match) begin
                            err_n = '0;
                        end else if (err_inc >= LOSS_N) begin
                            err_n   = '0;
                            cnt_n   = '0;
                            state_n = HUNT;
                        end else begin
                            err_n = err_inc;
                        end
                    end
                end
                default: state_n = HUNT;
            endcase
        end
    end

    always_ff @(posedge px_clk) begin
        if (px_reset) begin
            norm_q <= '0;
            win_q  <= '0;
            state  <= HUNT;
            cnt    <= '0;
            err    <= '0;
            ofs    <= '0;
            data   <= '0;
        end else begin
            norm_q <= norm_n;
            win_q  <= {win_q[W-1:0], norm_q};
            state  <= state_n;
            cnt    <= cnt_n;
            err    <= err_n;
            ofs    <= ofs_n;
            data   <= cand[ofs];
        end
    end

    assign locked = (state == LOCKED);
    assign offset = ofs;

`ifdef RX_ALIGN_STATS_EN
    logic [15:0] relock_q;

    always_ff @(posedge px_clk) begin
        if (px_reset) begin
            relock_q <= '0;
        end else if (state == LOCKED && state_n == HUNT && relock_q != 16'hFFFF) begin
            relock_q <= relock_q + 16'd1;
        end
    end

    assign relock_cnt = relock_q;
`else
    assign relock_cnt = '0;
`endif

endmodule

// File: rtl/rx_lane_align.sv
// Multi-lane word aligner top: one rx_lane_align_fsm per lane plus the all-lanes-locked valid flag.
// Optional macro RX_ALIGN_STATS_EN enables the per-lane relock counters.
module rx_lane_align
    import rx_align_pkg::*;
#(
    parameter int               LANES        = 4,
    parameter int               W            = W_DEF,
    parameter logic [LANES-1:0] RX_SWAP_MASK = '0,
    parameter bit               BIT_REVERSE  = 1'b1,
    parameter logic [W-1:0]     TRAIN_WORD   = 'hF0,
    parameter int               LOCK_CNT     = 4,
    parameter int               LOSS_CNT     = 8,
    localparam int              OW           = $clog2(W)
) (
    input  logic                px_clk,
    input  logic                px_reset,
    input  logic [LANES*W-1:0]  rx_words,
    input  logic                train_mode,
    input  logic                align_req,
    output logic [LANES*W-1:0]  px_data,
    output logic                px_valid,
    output logic [LANES-1:0]    lane_locked,
    output logic [LANES*OW-1:0] lane_offset,
    output logic [LANES*16-1:0] lane_relock_cnt
);

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        rx_lane_align_fsm #(
            .W           (W),
            .OW          (OW),
            .INVERT      (RX_SWAP_MASK[i]),
            .BIT_REVERSE (BIT_REVERSE),
            .TRAIN_WORD  (TRAIN_WORD),
            .LOCK_CNT    (LOCK_CNT),
            .LOSS_CNT    (LOSS_CNT)
        ) u_lane (
            .px_clk     (px_clk),
            .px_reset   (px_reset),
            .raw        (rx_words[i*W +: W]),
            .train_mode (train_mode),
            .align_req  (align_req),
            .data       (px_data[i*W +: W]),
            .locked     (lane_locked[i]),
            .offset     (lane_offset[i*OW +: OW]),
            .relock_cnt (lane_relock_cnt[i*16 +: 16])
        );
    end

    always_ff @(posedge px_clk) begin
        if (px_reset) px_valid <= 1'b0;
        else          px_valid <= &lane_locked;
    end

endmodule

// File: tb/tb_rx_lane_align.sv
// Directed self-checking bench for rx_lane_align (4 lanes, W=8, lane 1 inverted, bit reverse on).
module tb_rx_lane_align;

    logic        px_clk = 1'b0;
    logic        px_reset;
    logic [31:0] rx_words;
    logic        train_mode;
    logic        align_req;
    logic [31:0] px_data;
    logic        px_valid;
    logic [3:0]  lane_locked;
    logic [11:0] lane_offset;
    logic [63:0] lane_relock_cnt;

    logic [7:0]  nw [4];
    int          errors = 0;
    int          checks = 0;

    localparam logic [11:0] OFS_MIX = {3'd7, 3'd5, 3'd2, 3'd0};

    rx_lane_align #(
        .LANES        (4),
        .W            (8),
        .RX_SWAP_MASK (4'b0010),
        .BIT_REVERSE  (1'b1),
        .TRAIN_WORD   (8'hF0),
        .LOCK_CNT     (4),
        .LOSS_CNT     (8)
    ) dut (
        .px_clk          (px_clk),
        .px_reset        (px_reset),
        .rx_words        (rx_words),
        .train_mode      (train_mode),
        .align_req       (align_req),
        .px_data         (px_data),
        .px_valid        (px_valid),
        .lane_locked     (lane_locked),
        .lane_offset     (lane_offset),
        .lane_relock_cnt (lane_relock_cnt)
    );

    always #5 px_clk = ~px_clk;

    // Word whose rotate-left by k gives x: what a lane must carry to align at offset k.
    function automatic logic [7:0] rotr(input logic [7:0] x, input int k);
        logic [15:0] d;
        d = {x, x};
        return d[k +: 8];
    endfunction

    function automatic logic [7:0] rev8(input logic [7:0] x);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = x[7-i];
        return r;
    endfunction

    task automatic drive();
        for (int i = 0; i < 4; i++)
            rx_words[i*8 +: 8] = rev8(nw[i]) ^ ((i == 1) ? 8'hFF : 8'h00);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge px_clk);
        #1;
    endtask

    task automatic do_reset();
        px_reset   = 1'b1;
        train_mode = 1'b0;
        align_req  = 1'b0;
        for (int i = 0; i < 4; i++) nw[i] = 8'h00;
        drive();
        cyc(2);
        px_reset = 1'b0;
    endtask

    task automatic set_mix(input logic [7:0] base);
        nw[0] = rotr(base, 0);
        nw[1] = rotr(base, 2);
        nw[2] = rotr(base, 5);
        nw[3] = rotr(base, 7);
        drive();
    endtask

    task automatic lock_mix();
        do_reset();
        set_mix(8'hF0);
        train_mode = 1'b1;
        cyc(8);
    endtask

    task automatic test_reset();
        px_reset   = 1'b1;
        train_mode = 1'b1;
        align_req  = 1'b0;
        set_mix(8'hF0);
        cyc(3);
        checks++; if (px_data !== 32'h0) begin errors++; $display("FAIL reset_px_data: got %h want %h", px_data, 32'h0); end
        checks++; if (px_valid !== 1'b0) begin errors++; $display("FAIL reset_px_valid: got %b want 0", px_valid); end
        checks++; if (lane_locked !== 4'h0) begin errors++; $display("FAIL reset_locked: got %b want 0000", lane_locked); end
        checks++; if (lane_offset !== 12'h0) begin errors++; $display("FAIL reset_offset: got %h want 000", lane_offset); end
        checks++; if (lane_relock_cnt !== 64'h0) begin errors++; $display("FAIL reset_relock: got %h want 0", lane_relock_cnt); end
        px_reset = 1'b0;
    endtask

    task automatic test_single_lane();
        do_reset();
        nw[0] = rotr(8'hF0, 3);
        drive();
        train_mode = 1'b1;
        cyc(4);
        checks++; if (lane_offset[2:0] !== 3'd3) begin errors++; $display("FAIL single_offset: got %0d want 3", lane_offset[2:0]); end
        checks++; if (lane_locked !== 4'b0000) begin errors++; $display("FAIL single_check1: got %b want 0000", lane_locked); end
        cyc(2);
        checks++; if (lane_locked !== 4'b0000) begin errors++; $display("FAIL single_check3: got %b want 0000", lane_locked); end
        cyc(1);
        checks++; if (lane_locked !== 4'b0001) begin errors++; $display("FAIL single_locked: got %b want 0001", lane_locked); end
        checks++; if (px_data[7:0] !== 8'hF0) begin errors++; $display("FAIL single_data: got %h want f0", px_data[7:0]); end
        checks++; if (px_valid !== 1'b0) begin errors++; $display("FAIL single_valid: got %b want 0", px_valid); end
    endtask

    task automatic test_all_lanes();
        do_reset();
        set_mix(8'hF0);
        train_mode = 1'b1;
        cyc(7);
        checks++; if (lane_locked !== 4'hF) begin errors++; $display("FAIL all_locked: got %b want 1111", lane_locked); end
        checks++; if (px_valid !== 1'b0) begin errors++; $display("FAIL all_valid_early: got %b want 0", px_valid); end
        checks++; if (lane_offset !== OFS_MIX) begin errors++; $display("FAIL all_offsets: got %h want %h", lane_offset, OFS_MIX); end
        cyc(1);
        checks++; if (px_valid !== 1'b1) begin errors++; $display("FAIL all_valid: got %b want 1", px_valid); end
        train_mode = 1'b0;
        set_mix(8'hA5);
        cyc(4);
        checks++; if (px_data !== 32'hA5A5A5A5) begin errors++; $display("FAIL all_data: got %h want a5a5a5a5", px_data); end
        checks++; if (px_valid !== 1'b1) begin errors++; $display("FAIL all_data_valid: got %b want 1", px_valid); end
    endtask

    task automatic test_loss();
        lock_mix();
        nw[0] = 8'h00;
        drive();
        cyc(8);
        nw[0] = 8'hF0;
        drive();
        cyc(2);
        checks++; if (lane_locked !== 4'hF) begin errors++; $display("FAIL loss_err7: got %b want 1111", lane_locked); end
        cyc(1);
        checks++; if (lane_locked !== 4'b1110) begin errors++; $display("FAIL loss_hunt: got %b want 1110", lane_locked); end
        checks++; if (px_valid !== 1'b1) begin errors++; $display("FAIL loss_valid_lag: got %b want 1", px_valid); end
        cyc(1);
        checks++; if (px_valid !== 1'b0) begin errors++; $display("FAIL loss_valid_drop: got %b want 0", px_valid); end
        cyc(4);
        checks++; if (lane_locked !== 4'hF) begin errors++; $display("FAIL loss_relock: got %b want 1111", lane_locked); end
        checks++; if (px_valid !== 1'b1) begin errors++; $display("FAIL loss_relock_valid: got %b want 1", px_valid); end
        nw[0] = 8'h00;
        drive();
        cyc(7);
        nw[0] = 8'hF0;
        drive();
        for (int c = 0; c < 8; c++) begin
            cyc(1);
            checks++; if (lane_locked !== 4'hF) begin errors++; $display("FAIL loss_seven_hold c%0d: got %b want 1111", c, lane_locked); end
        end
        checks++; if (px_valid !== 1'b1) begin errors++; $display("FAIL loss_seven_valid: got %b want 1", px_valid); end
    endtask

    task automatic test_align_req();
        lock_mix();
        train_mode = 1'b0;
        checks++; if (px_valid !== 1'b1) begin errors++; $display("FAIL areq_pre_valid: got %b want 1", px_valid); end
        align_req = 1'b1;
        cyc(1);
        align_req = 1'b0;
        checks++; if (lane_locked !== 4'h0) begin errors++; $display("FAIL areq_hunt: got %b want 0000", lane_locked); end
        checks++; if (lane_offset !== OFS_MIX) begin errors++; $display("FAIL areq_offset_held: got %h want %h", lane_offset, OFS_MIX); end
        train_mode = 1'b1;
        cyc(1);
        checks++; if (px_valid !== 1'b0) begin errors++; $display("FAIL areq_valid: got %b want 0", px_valid); end
        cyc(2);
        checks++; if (lane_locked !== 4'h0) begin errors++; $display("FAIL areq_check3: got %b want 0000", lane_locked); end
        align_req = 1'b1;
        cyc(1);
        align_req = 1'b0;
        checks++; if (lane_locked !== 4'h0) begin errors++; $display("FAIL areq_priority: got %b want 0000", lane_locked); end
        cyc(5);
        checks++; if (lane_locked !== 4'hF) begin errors++; $display("FAIL areq_relock: got %b want 1111", lane_locked); end
        checks++; if (px_valid !== 1'b1) begin errors++; $display("FAIL areq_relock_valid: got %b want 1", px_valid); end
    endtask

    task automatic test_swap();
        do_reset();
        for (int i = 0; i < 4; i++) nw[i] = rotr(8'hF0, 4);
        drive();
        train_mode = 1'b1;
        cyc(8);
        checks++; if (lane_offset !== 12'h924) begin errors++; $display("FAIL swap_offsets: got %h want 924", lane_offset); end
        checks++; if (lane_locked !== 4'hF) begin errors++; $display("FAIL swap_locked: got %b want 1111", lane_locked); end
        checks++; if (px_data !== 32'hF0F0F0F0) begin errors++; $display("FAIL swap_data: got %h want f0f0f0f0", px_data); end
    endtask

    task automatic test_reset_mid_check();
        do_reset();
        set_mix(8'hF0);
        train_mode = 1'b1;
        cyc(5);
        checks++; if (lane_offset !== OFS_MIX) begin errors++; $display("FAIL midrst_pre_offset: got %h want %h", lane_offset, OFS_MIX); end
        checks++; if (lane_locked !== 4'h0) begin errors++; $display("FAIL midrst_pre_locked: got %b want 0000", lane_locked); end
        px_reset = 1'b1;
        cyc(1);
        checks++; if (px_data !== 32'h0) begin errors++; $display("FAIL midrst_data: got %h want 0", px_data); end
        checks++; if (lane_offset !== 12'h0) begin errors++; $display("FAIL midrst_offset: got %h want 000", lane_offset); end
        checks++; if (lane_locked !== 4'h0 || px_valid !== 1'b0) begin errors++; $display("FAIL midrst_status: got %b/%b want 0000/0", lane_locked, px_valid); end
        px_reset = 1'b0;
    endtask

    task automatic test_stats();
        logic [63:0] exp_cnt;
        lock_mix();
        for (int n = 0; n < 2; n++) begin
            nw[0] = 8'h00;
            drive();
            cyc(8);
            nw[0] = 8'hF0;
            drive();
            cyc(8);
        end
        checks++; if (lane_locked !== 4'hF) begin errors++; $display("FAIL stats_relocked: got %b want 1111", lane_locked); end
        align_req = 1'b1;
        cyc(1);
        align_req = 1'b0;
`ifdef RX_ALIGN_STATS_EN
        exp_cnt = {16'd1, 16'd1, 16'd1, 16'd3};
`else
        exp_cnt = 64'h0;
`endif
        checks++; if (lane_relock_cnt !== exp_cnt) begin errors++; $display("FAIL stats_relock_cnt: got %h want %h", lane_relock_cnt, exp_cnt); end
    endtask

    initial begin
        px_reset   = 1'b1;
        train_mode = 1'b0;
        align_req  = 1'b0;
        rx_words   = '0;
        test_reset();
        test_single_lane();
        test_all_lanes();
        test_loss();
        test_align_req();
        test_swap();
        test_reset_mid_check();
        test_stats();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
